// File: rtl/gate4_vector_checker.sv
// ---------------------------------------------------------------------------
// gate4_vector_checker : steps vectors 0..N-1 into a 4-input AND/OR/XOR
// reduction block and scores its responses.  Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module gate4_vector_checker #(
  parameter int NUM_VECTORS = 16,
  parameter int LATENCY     = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [3:0] stim,
  input  logic       dut_and,
  input  logic       dut_or,
  input  logic       dut_xor,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [3:0] first_fail_vec,
  output logic       first_fail_valid
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRIVE = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [7:0] c_last_idx  = 8'(NUM_VECTORS - 1);
  localparam logic [2:0] c_wait_load = (LATENCY > 0) ? 3'(LATENCY - 1) : 3'd0;

  state_t     state_q, state_d;
  logic [3:0] stim_q, stim_d;
  logic [7:0] index_q, index_d;
  logic [2:0] wait_q, wait_d;
  logic [7:0] err_q, err_d;
  logic [3:0] ffv_q, ffv_d;
  logic       ffvalid_q, ffvalid_d;
  logic       pass_q, pass_d;
  logic       w_mismatch;

  assign w_mismatch = (dut_and != (&stim_q)) ||
                      (dut_or  != (|stim_q)) ||
                      (dut_xor != (^stim_q));

  always_comb begin
    state_d   = state_q;
    stim_d    = stim_q;
    index_d   = index_q;
    wait_d    = wait_q;
    err_d     = err_q;
    ffv_d     = ffv_q;
    ffvalid_d = ffvalid_q;
    pass_d    = pass_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          err_d     = 8'd0;
          ffv_d     = 4'd0;
          ffvalid_d = 1'b0;
          pass_d    = 1'b0;
          index_d   = 8'd0;
          state_d   = S_DRIVE;
        end
      end
      S_DRIVE: begin
        stim_d  = index_q[3:0];
        wait_d  = c_wait_load;
        state_d = (LATENCY > 0) ? S_WAIT : S_CHECK;
      end
      S_WAIT: begin
        if (wait_q == 3'd0) begin
          state_d = S_CHECK;
        end else begin
          wait_d = wait_q - 3'd1;
        end
      end
      S_CHECK: begin
        if (w_mismatch) begin
          if (err_q != 8'hFF) begin
            err_d = err_q + 8'd1;
          end
          if (!ffvalid_q) begin
            ffv_d     = stim_q;
            ffvalid_d = 1'b1;
          end
        end
        // pass reflects the count including this final vector's result
        if (index_q == c_last_idx) begin
          state_d = S_DONE;
          pass_d  = (err_d == 8'd0);
        end else begin
          index_d = index_q + 8'd1;
          state_d = S_DRIVE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      stim_q    <= 4'd0;
      index_q   <= 8'd0;
      wait_q    <= 3'd0;
      err_q     <= 8'd0;
      ffv_q     <= 4'd0;
      ffvalid_q <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      stim_q    <= stim_d;
      index_q   <= index_d;
      wait_q    <= wait_d;
      err_q     <= err_d;
      ffv_q     <= ffv_d;
      ffvalid_q <= ffvalid_d;
      pass_q    <= pass_d;
    end
  end

  assign stim             = stim_q;
  assign busy             = (state_q == S_DRIVE) || (state_q == S_WAIT) || (state_q == S_CHECK);
  assign done             = (state_q == S_DONE);
  assign pass             = pass_q;
  assign err_count        = err_q;
  assign first_fail_vec   = ffv_q;
  assign first_fail_valid = ffvalid_q;

endmodule

`default_nettype wire
